// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer: FSM states, key-length codes
// and the round-count lookup.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_INIT   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] KEY_LEN_128 = 2'd0;
    localparam logic [1:0] KEY_LEN_192 = 2'd1;
    localparam logic [1:0] KEY_LEN_256 = 2'd2;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // The reserved code 3 falls back to AES-128.
    function automatic logic [3:0] nr_lookup(input logic [1:0] kl);
        case (kl)
            KEY_LEN_128: return NR_128;
            KEY_LEN_192: return NR_192;
            KEY_LEN_256: return NR_256;
            default:     return NR_128;
        endcase
    endfunction

    // Round index shown in INIT: 0 for encryption, Nr for decryption.
    function automatic logic [3:0] init_idx(input logic dec, input logic [3:0] nr);
        return dec ? nr : 4'd0;
    endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Loadable up/down counter with enable and terminal-count flag; also exposes the
// value it will hold after the next edge so callers can register derived outputs.
module aes_round_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (en) begin
            count_next = up ? count_reg + W'(1) : count_reg - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign tc    = (count_reg == term_val);

endmodule

// File: rtl/aes_round_sequencer.sv
// Round-control FSM for the AES core (AES-128/192/256) with start/busy/done handshake,
// key-expansion gating and datapath stall. Define AES_DECRYPT_EN for descending rounds.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR_MAX   = 14,
    parameter int KEXP_LAT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        key_len,
    input  logic              key_change,
    input  logic              hold,
`ifdef AES_DECRYPT_EN
    input  logic              decrypt,
`endif
    output logic              busy,
    output logic              done,
    output logic              key_load,
    output logic [3:0]        round_idx,
    output logic [NR_MAX-1:0] round_onehot,
    output logic              first_round,
    output logic              last_round
);

    state_t      state_reg, state_next;
    logic [3:0]  nr_reg, nr_next;
    logic        key_pending_reg, key_pending_next;
    logic        decrypt_reg, decrypt_next, decrypt_sel;

    logic        rc_load, rc_en, rc_tc;
    logic [3:0]  rc_load_val, rc_count, rc_count_next, rc_term;
    logic        kexp_load, kexp_en, kexp_tc;
    logic [3:0]  kexp_count, kexp_count_next;
    logic        kexp_unused;

    logic              busy_reg, done_reg, key_load_reg, first_round_reg, last_round_reg;
    logic [NR_MAX-1:0] onehot_reg, onehot_next;
    logic [3:0]        bit_idx;
    logic              in_round_next;

`ifdef AES_DECRYPT_EN
    assign decrypt_sel = decrypt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            decrypt_reg <= 1'b0;
        end else begin
            decrypt_reg <= decrypt_next;
        end
    end
`else
    logic decrypt_unused;
    assign decrypt_sel    = 1'b0;
    assign decrypt_reg    = 1'b0;
    assign decrypt_unused = decrypt_next;
`endif

    assign rc_term = decrypt_reg ? 4'd0 : nr_reg;

    aes_round_counter #(.W(4)) u_round_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (rc_load),
        .load_val   (rc_load_val),
        .en         (rc_en),
        .up         (~decrypt_reg),
        .term_val   (rc_term),
        .count      (rc_count),
        .count_next (rc_count_next),
        .tc         (rc_tc)
    );

    // Counts KEXP_LAT-1 down to 0; terminal count marks the last KEYEXP cycle.
    aes_round_counter #(.W(4)) u_kexp_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (kexp_load),
        .load_val   (4'(KEXP_LAT - 1)),
        .en         (kexp_en),
        .up         (1'b0),
        .term_val   (4'd0),
        .count      (kexp_count),
        .count_next (kexp_count_next),
        .tc         (kexp_tc)
    );

    assign kexp_unused = ^{kexp_count, kexp_count_next};

    always_comb begin
        state_next       = state_reg;
        nr_next          = nr_reg;
        decrypt_next     = decrypt_reg;
        key_pending_next = key_pending_reg | key_change;
        rc_load          = 1'b0;
        rc_load_val      = 4'd0;
        rc_en            = 1'b0;
        kexp_load        = 1'b0;
        kexp_en          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    nr_next      = nr_lookup(key_len);
                    decrypt_next = decrypt_sel;
                    // A key change arriving with the start still forces expansion.
                    if (key_pending_reg || key_change) begin
                        state_next       = ST_KEYEXP;
                        key_pending_next = 1'b0;
                        kexp_load        = 1'b1;
                    end else begin
                        state_next  = ST_INIT;
                        rc_load     = 1'b1;
                        rc_load_val = init_idx(decrypt_next, nr_next);
                    end
                end
            end
            ST_KEYEXP: begin
                if (!hold) begin
                    kexp_en = 1'b1;
                    if (kexp_tc) begin
                        state_next  = ST_INIT;
                        rc_load     = 1'b1;
                        rc_load_val = init_idx(decrypt_reg, nr_reg);
                    end
                end
            end
            ST_INIT: begin
                if (!hold) begin
                    state_next = ST_ROUND;
                    rc_en      = 1'b1;
                end
            end
            ST_ROUND: begin
                if (!hold) begin
                    if (rc_tc) begin
                        state_next  = ST_DONE;
                        rc_load     = 1'b1;
                        rc_load_val = 4'd0;
                    end else begin
                        rc_en = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_round_next = (state_next == ST_ROUND);
    assign bit_idx       = decrypt_reg ? rc_count_next : rc_count_next - 4'd1;

    genvar gi;
    generate
        for (gi = 0; gi < NR_MAX; gi++) begin : g_onehot
            assign onehot_next[gi] = in_round_next && (32'(bit_idx) == 32'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            nr_reg          <= NR_128;
            key_pending_reg <= 1'b1;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            key_load_reg    <= 1'b0;
            first_round_reg <= 1'b0;
            last_round_reg  <= 1'b0;
            onehot_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            nr_reg          <= nr_next;
            key_pending_reg <= key_pending_next;
            busy_reg        <= (state_next == ST_KEYEXP) || (state_next == ST_INIT) || in_round_next;
            done_reg        <= (state_next == ST_DONE);
            key_load_reg    <= (state_reg == ST_IDLE) && (state_next == ST_KEYEXP);
            first_round_reg <= (state_next == ST_INIT);
            last_round_reg  <= in_round_next && (rc_count_next == rc_term);
            onehot_reg      <= onehot_next;
        end
    end

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign key_load     = key_load_reg;
    assign round_idx    = rc_count;
    assign round_onehot = onehot_reg;
    assign first_round  = first_round_reg;
    assign last_round   = last_round_reg;

endmodule
